// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared states and command constants for the SPI flash responder
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        ID,
        IGNORE
    } state_t;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_JEDEC  = 8'h9F;
    localparam int         ADDR_BYTES = 3;

endpackage

// File: rtl/spi_flash_responder_sync.sv
// rtl/spi_flash_responder_sync.sv - 2-flop synchronizer with rise/fall detection (module spi_sync_edge)
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= RESET_VAL;
            s2 <= RESET_VAL;
            s3 <= RESET_VAL;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - mode-0 SPI flash target answering READ; JEDEC ID via SPI_RESP_JEDEC_EN
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          DEPTH    = 256,
    parameter int          ADDR_W   = 8,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              busy,
    output logic [7:0]        txn_count
);

    localparam logic [4:0] ADDR_LAST = 5'(ADDR_BYTES * 8 - 1);

    state_t              state, next_state;
    logic                cs_rise, cs_fall, sclk_rise, sclk_fall;
    logic [1:0]          mosi_sync;
    logic                mosi_s;
    logic [4:0]          bit_cnt;
    logic [6:0]          rx_sh;
    logic [7:0]          cmd_byte;
    logic [ADDR_W-1:0]   addr, addr_next, rd_addr;
    logic [7:0]          tx_sh, mem_rdata, txn_q;
    logic                miso_q, load_pending, rd_en;
    logic [1:0]          id_idx;
    logic [7:0]          mem [DEPTH];

    // CS idles high, so its synchronizer resets high to avoid a phantom edge
    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .din(spi_cs_n), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b0)) u_clk_sync (
        .clk(clk), .rst(rst), .din(spi_clk), .rise(sclk_rise), .fall(sclk_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) mosi_sync <= 2'b00;
        else     mosi_sync <= {mosi_sync[0], spi_mosi};
    end
    assign mosi_s    = mosi_sync[1];
    assign cmd_byte  = {rx_sh, mosi_s};
    assign addr_next = {addr[ADDR_W-2:0], mosi_s};

    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        case (idx)
            2'd1:    return JEDEC_ID[15:8];
            2'd2:    return JEDEC_ID[7:0];
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        rd_addr    = addr;
        if (cs_rise) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: if (cs_fall) next_state = CMD;
                CMD: if (sclk_rise && bit_cnt == 5'd7) begin
                    if (cmd_byte == CMD_READ) next_state = ADDR;
`ifdef SPI_RESP_JEDEC_EN
                    else if (cmd_byte == CMD_JEDEC) next_state = ID;
`endif
                    else next_state = IGNORE;
                end
                ADDR: if (sclk_rise && bit_cnt == ADDR_LAST) begin
                    next_state = DATA;
                    rd_en      = 1'b1;
                    rd_addr    = addr_next;
                end
                DATA: if (sclk_fall && bit_cnt == 5'd7) begin
                    rd_en   = 1'b1;
                    rd_addr = addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cs_rise) begin
            bit_cnt      <= '0;
            rx_sh        <= '0;
            addr         <= '0;
            tx_sh        <= '0;
            miso_q       <= 1'b0;
            load_pending <= 1'b0;
            id_idx       <= '0;
        end else begin
            // Memory data arrives one clk after the read; legal SCLK timing keeps this clear of the next fall
            if (load_pending) begin
                tx_sh        <= mem_rdata;
                load_pending <= 1'b0;
            end
            case (state)
                CMD: if (sclk_rise) begin
                    rx_sh   <= cmd_byte[6:0];
                    bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
                    if (bit_cnt == 5'd7 && next_state == ID) begin
                        tx_sh  <= JEDEC_ID[23:16];
                        id_idx <= 2'd1;
                    end
                end
                ADDR: if (sclk_rise) begin
                    addr    <= addr_next;
                    bit_cnt <= (bit_cnt == ADDR_LAST) ? 5'd0 : bit_cnt + 5'd1;
                    if (bit_cnt == ADDR_LAST) load_pending <= 1'b1;
                end
                DATA: if (sclk_fall) begin
                    miso_q  <= tx_sh[7];
                    tx_sh   <= {tx_sh[6:0], 1'b0};
                    bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
                    if (bit_cnt == 5'd7) begin
                        addr         <= addr + 1'b1;
                        load_pending <= 1'b1;
                    end
                end
                ID: if (sclk_fall) begin
                    miso_q <= tx_sh[7];
                    if (bit_cnt == 5'd7) begin
                        bit_cnt <= 5'd0;
                        tx_sh   <= id_byte(id_idx);
                        id_idx  <= (id_idx == 2'd3) ? 2'd3 : id_idx + 2'd1;
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)          txn_q <= 8'd0;
        else if (cs_rise) txn_q <= txn_q + 8'd1;
    end

    // Read-before-write on a same-index collision falls out of non-blocking semantics
    always_ff @(posedge clk) begin
        if (load_we) mem[load_addr] <= load_data;
        if (rd_en)   mem_rdata      <= mem[rd_addr];
    end

    assign busy        = (state != IDLE);
    assign spi_miso_oe = busy;
    assign spi_miso    = miso_q;
    assign txn_count   = txn_q;

endmodule
